// File: rtl/clk_div_gen.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_gen
// Purpose  : Glitch-free runtime-programmable integer clock divider with
//            optional exact 50 % duty for odd ratios and a ref-clock bypass.
// Revision : 1.0  initial release
// ============================================================================
module clk_div_gen #(
  parameter int RATIO_W   = 8,
  parameter int RST_RATIO = 2
) (
  input  logic               i_ref_clk,
  input  logic               i_rst_n,
  input  logic               i_clk_en,
  input  logic [RATIO_W-1:0] i_div_ratio,
  input  logic               i_ratio_load,
  input  logic               i_duty_mode,
  output logic               o_div_clk,
  output logic               o_ratio_busy,
  output logic               o_period_tick
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BYPASS = 2'd1;
  localparam logic [1:0] DIVIDE = 2'd2;

  localparam logic [RATIO_W-1:0] C_ONE     = RATIO_W'(1);
  localparam logic [RATIO_W-1:0] C_RST_VAL = RATIO_W'(RST_RATIO);

  logic [1:0]         state_q, state_d;
  logic [RATIO_W-1:0] r_act_q, r_act_d;
  logic [RATIO_W-1:0] r_shd_q, r_shd_d;
  logic [RATIO_W-1:0] cnt_q, cnt_d;
  logic               mode_act_q, mode_act_d;
  logic               busy_q, busy_d;
  logic               tick_q, tick_d;
  logic               pos_q, pos_d;
  logic               neg_q, neg_d;
  logic               byp_sel_q, byp_sel_d;

  logic               w_boundary;
  logic [RATIO_W-1:0] w_next_ratio;
  logic [RATIO_W-1:0] w_half;

  always_comb begin
    state_d    = state_q;
    r_act_d    = r_act_q;
    r_shd_d    = r_shd_q;
    cnt_d      = cnt_q;
    mode_act_d = mode_act_q;
    busy_d     = busy_q;
    tick_d     = 1'b0;
    pos_d      = pos_q;

    w_boundary   = (state_q != DIVIDE) || (cnt_q == (r_act_q - C_ONE));
    w_next_ratio = i_ratio_load ? i_div_ratio : (busy_q ? r_shd_q : r_act_q);
    // High-phase length in posedge cycles: floor(N/2) in mode 1, else ceil(N/2)
    w_half       = mode_act_q ? (r_act_q >> 1)
                              : ((r_act_q >> 1) + {{(RATIO_W-1){1'b0}}, r_act_q[0]});

    if (w_boundary) begin
      r_act_d    = w_next_ratio;
      busy_d     = 1'b0;
      mode_act_d = i_duty_mode;
      cnt_d      = '0;
      if (!i_clk_en) begin
        state_d = IDLE;
      end else if (w_next_ratio < RATIO_W'(2)) begin
        state_d = BYPASS;
      end else begin
        state_d = DIVIDE;
      end
      pos_d  = (state_d == DIVIDE);
      tick_d = (state_d == DIVIDE);
    end else begin
      cnt_d = cnt_q + C_ONE;
      pos_d = (cnt_d < w_half);
      if (i_ratio_load) begin
        r_shd_d = i_div_ratio;
        busy_d  = 1'b1;
      end
    end

    neg_d     = (state_q == DIVIDE && mode_act_q && r_act_q[0]) ? pos_q : 1'b0;
    byp_sel_d = (state_q == BYPASS);
  end

  always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      r_act_q    <= C_RST_VAL;
      r_shd_q    <= '0;
      cnt_q      <= '0;
      mode_act_q <= 1'b0;
      busy_q     <= 1'b0;
      tick_q     <= 1'b0;
      pos_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      r_act_q    <= r_act_d;
      r_shd_q    <= r_shd_d;
      cnt_q      <= cnt_d;
      mode_act_q <= mode_act_d;
      busy_q     <= busy_d;
      tick_q     <= tick_d;
      pos_q      <= pos_d;
    end
  end

  // Falling-edge flops: half-cycle stretch and mux select change only while ref is low
  always_ff @(negedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      neg_q     <= 1'b0;
      byp_sel_q <= 1'b0;
    end else begin
      neg_q     <= neg_d;
      byp_sel_q <= byp_sel_d;
    end
  end

  assign o_div_clk     = byp_sel_q ? i_ref_clk : (pos_q | neg_q);
  assign o_ratio_busy  = busy_q;
  assign o_period_tick = tick_q;

endmodule
`default_nettype wire

// File: tb/tb_clk_div_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_clk_div_gen
// Purpose  : Scoreboard bench for clk_div_gen against a half-cycle waveform model.
// Revision : 1.0  initial release
// ============================================================================
module tb_clk_div_gen;

  logic       clk;
  logic       rst_n;
  logic       clk_en;
  logic [7:0] div_ratio;
  logic       ratio_load;
  logic       duty_mode;
  logic       div_clk;
  logic       ratio_busy;
  logic       period_tick;

  clk_div_gen #(.RATIO_W(8), .RST_RATIO(2)) dut (
    .i_ref_clk    (clk),
    .i_rst_n      (rst_n),
    .i_clk_en     (clk_en),
    .i_div_ratio  (div_ratio),
    .i_ratio_load (ratio_load),
    .i_duty_mode  (duty_mode),
    .o_div_clk    (div_clk),
    .o_ratio_busy (ratio_busy),
    .o_period_tick(period_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit hi;
    bit lo;
    bit tick;
    bit busy;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;
  int   cycle = 0;

  localparam int S_IDLE = 0;
  localparam int S_BYP  = 1;
  localparam int S_DIV  = 2;

  int m_state, m_act, m_shd, m_k;
  bit m_busy, m_mode, m_prev_byp;
  bit cur_mode;

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0d want=%0d", name, cycle, got, want);
    end
  endtask

  task automatic model_reset();
    m_state = S_IDLE; m_act = 2; m_shd = 0; m_k = 0;
    m_busy = 0; m_mode = 0; m_prev_byp = 0;
    sbq.delete();
  endtask

  // One posedge of the reference model: the whole period shape follows from N and mode.
  task automatic model_step(input bit en, input bit ld, input int ratio, input bit md);
    exp_t e;
    int   nr;
    int   hc;
    if (m_state != S_DIV || m_k == m_act - 1) begin
      nr      = ld ? ratio : (m_busy ? m_shd : m_act);
      m_act   = nr;
      m_busy  = 0;
      m_mode  = md;
      m_k     = 0;
      m_state = !en ? S_IDLE : (nr < 2 ? S_BYP : S_DIV);
    end else begin
      m_k++;
      if (ld) begin
        m_shd  = ratio;
        m_busy = 1;
      end
    end
    if (m_state == S_DIV) begin
      hc     = (m_mode && (m_act % 2 == 1)) ? m_act : 2 * ((m_act + 1) / 2);
      e.hi   = (2 * m_k < hc);
      e.lo   = (2 * m_k + 1 < hc);
      e.tick = (m_k == 0);
    end else begin
      e.hi   = m_prev_byp;
      e.lo   = 0;
      e.tick = 0;
    end
    e.busy     = m_busy;
    m_prev_byp = (m_state == S_BYP);
    sbq.push_back(e);
  endtask

  task automatic cyc(input bit en, input bit ld, input int ratio, input bit md);
    @(negedge clk);
    clk_en = en; ratio_load = ld; div_ratio = 8'(ratio); duty_mode = md;
    @(posedge clk);
    cycle++;
    model_step(en, ld, ratio, md);
  endtask

  task automatic release_rst();
    @(negedge clk);
    clk_en = 1; ratio_load = 0; div_ratio = 0; duty_mode = cur_mode;
    rst_n = 1;
    @(posedge clk);
    cycle++;
    model_step(1, 0, 0, cur_mode);
  endtask

  task automatic wait_k(input int n, input int k);
    int guard = 0;
    while (!(m_state == S_DIV && m_act == n && m_k == k) && guard < 40) begin
      cyc(1, 0, 0, cur_mode);
      guard++;
    end
    if (guard >= 40) chk("wait_k_timeout", guard, 0);
  endtask

  // Monitor: one scoreboard entry per modelled ref cycle, both phases sampled.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("div_clk_hi", int'(div_clk), int'(e.hi));
        chk("period_tick", int'(period_tick), int'(e.tick));
        chk("ratio_busy", int'(ratio_busy), int'(e.busy));
        @(negedge clk);
        #1;
        if (rst_n) chk("div_clk_lo", int'(div_clk), int'(e.lo));
      end
    end
  end

  initial begin
    rst_n = 0; clk_en = 0; ratio_load = 0; div_ratio = 0; duty_mode = 0;
    cur_mode = 0;
    model_reset();
    #1;
    chk("rst_div_clk", int'(div_clk), 0);
    chk("rst_busy", int'(ratio_busy), 0);
    chk("rst_tick", int'(period_tick), 0);
    repeat (2) @(posedge clk);

    // Reset ratio 2 straight out of reset
    release_rst();
    repeat (8) cyc(1, 0, 0, cur_mode);

    // N=5 mode 0, then mode 1
    cyc(1, 1, 5, cur_mode);
    repeat (12) cyc(1, 0, 0, cur_mode);
    cur_mode = 1;
    cyc(1, 1, 5, cur_mode);
    repeat (12) cyc(1, 0, 0, cur_mode);
    cur_mode = 0;

    // Shadow overwrite during an N=8 period
    cyc(1, 1, 8, cur_mode);
    wait_k(8, 2);
    cyc(1, 1, 6, cur_mode);
    wait_k(8, 4);
    cyc(1, 1, 3, cur_mode);
    repeat (14) cyc(1, 0, 0, cur_mode);

    // Bypass entry and exit
    cyc(1, 1, 1, cur_mode);
    repeat (8) cyc(1, 0, 0, cur_mode);
    cyc(1, 1, 4, cur_mode);
    repeat (10) cyc(1, 0, 0, cur_mode);

    // Enable dropped mid-period, then restored
    cyc(1, 1, 6, cur_mode);
    wait_k(6, 1);
    repeat (12) cyc(0, 0, 0, cur_mode);
    repeat (8) cyc(1, 0, 0, cur_mode);

    // Reset during the high phase of N=7 mode 1
    cur_mode = 1;
    cyc(1, 1, 7, cur_mode);
    wait_k(7, 0);
    cyc(1, 0, 0, cur_mode);
    #2;
    rst_n = 0;
    #1;
    model_reset();
    chk("midrst_div_clk", int'(div_clk), 0);
    chk("midrst_busy", int'(ratio_busy), 0);
    chk("midrst_tick", int'(period_tick), 0);
    repeat (2) @(negedge clk);
    chk("midrst_hold", int'(div_clk), 0);
    cur_mode = 0;
    release_rst();
    repeat (8) cyc(1, 0, 0, cur_mode);

    // Randomised traffic
    for (int i = 0; i < 600; i++) begin
      bit en;
      bit ld;
      en = ($urandom_range(0, 19) != 0);
      ld = ($urandom_range(0, 7) == 0);
      cyc(en, ld, int'($urandom_range(0, 9)), 1'($urandom_range(0, 1)));
    end

    @(negedge clk);
    #2;
    chk("sb_drain", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout cycle=%0d got=running want=finished", cycle);
    $fatal(1);
  end

endmodule
`default_nettype wire
